// File: rtl/rsu_pkg.sv
// -----------------------------------------------------------------------------
// rsu_pkg
// Shared definitions for the remote-system-update sequencer:
//   - rsu_op_e      : command opcodes carried on cmd_op
//   - rsu_state_e   : sequencer FSM states
//   - PARAM_*       : parameter indices understood by the RSU IP on `param`
//   - RSP_TIMEOUT_PAT and helpers for the timeout counter / error word
// -----------------------------------------------------------------------------
package rsu_pkg;

   typedef enum logic [1:0] {
      OP_READ      = 2'd0,
      OP_RECONFIG  = 2'd1,
      OP_WDOG_KICK = 2'd2
   } rsu_op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_PULSE,
      ST_RD_WAIT_HI,
      ST_RD_WAIT_LO,
      ST_RSP,
      ST_RECFG,
      ST_HALT
   } rsu_state_e;

   // Parameter indices presented on rsu_param for READ
   localparam logic [2:0] PARAM_CFG_SOURCE  = 3'b000;
   localparam logic [2:0] PARAM_WDOG_VALUE  = 3'b010;
   localparam logic [2:0] PARAM_WDOG_ENABLE = 3'b011;
   localparam logic [2:0] PARAM_PAGE_ADDR   = 3'b100;
   localparam logic [2:0] PARAM_ANF         = 3'b101;

   localparam logic [31:0] RSP_TIMEOUT_PAT = 32'hDEAD_0000;
   localparam int          TMO_W           = 16;

   // Timeout counter never wraps, so a very long stall still reads as expired.
   function automatic logic [TMO_W-1:0] sat_inc(input logic [TMO_W-1:0] v);
      return (v == {TMO_W{1'b1}}) ? v : v + {{(TMO_W-1){1'b0}}, 1'b1};
   endfunction

   // Error word returned when a busy edge never arrives: pattern | param index.
   function automatic logic [31:0] timeout_word(input logic [2:0] p);
      return RSP_TIMEOUT_PAT | {29'd0, p};
   endfunction

endpackage

// File: rtl/rsu_wdog_timer.sv
// -----------------------------------------------------------------------------
// rsu_wdog_timer
// Free-running watchdog period counter with a pending flag. A tick is raised
// every WDOG_PERIOD running cycles; it stays pending until the sequencer
// acknowledges it by issuing a reset_timer pulse.
// Only instantiated when RSU_WDOG_EN is defined.
// Ports:
//   clock, reset_n : clock, asynchronous active-low reset
//   run   (in)     : counter advances only while high (low in HALT)
//   ack   (in)     : a reset_timer pulse is being issued this cycle
//   due   (out)    : a kick is owed (pending or ticking this cycle)
// -----------------------------------------------------------------------------
module rsu_wdog_timer #(
   parameter int WDOG_PERIOD = 50_000_000
) (
   input  logic clock,
   input  logic reset_n,
   input  logic run,
   input  logic ack,
   output logic due
);

   localparam int CW = (WDOG_PERIOD > 1) ? $clog2(WDOG_PERIOD) : 1;

   logic [CW-1:0] cnt;
   logic          pending;
   logic          tick;

   assign tick = run && (cnt == CW'(WDOG_PERIOD - 1));
   assign due  = pending | tick;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt     <= '0;
         pending <= 1'b0;
      end else begin
         if (tick)
            cnt <= '0;
         else if (run)
            cnt <= cnt + CW'(1);
         // A tick landing on the same cycle as a pulse merges into that pulse.
         pending <= (pending | tick) & ~ack;
      end
   end

endmodule

// File: rtl/rsu_ctrl.sv
// -----------------------------------------------------------------------------
// rsu_ctrl
// Sequencer in front of the remote-system-update IP. Accepts single-beat
// commands (READ, RECONFIG, WDOG_KICK), runs the IP read handshake and returns
// one 32-bit response per command; triggers reconfiguration and services the
// configuration watchdog.
// Optional feature macro: RSU_WDOG_EN (automatic watchdog kicks + WDOG_KICK op).
// Ports:
//   clock, reset_n        : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   : command handshake
//   cmd_op/param/nupdt    : opcode, READ parameter index, READ ctl_nupdt value
//   rsp_valid/data/err    : one-cycle response (no backpressure)
//   rsu_read_param, rsu_reconfig, rsu_reset_timer, rsu_param, rsu_ctl_nupdt
//                         : registered drives into the IP
//   rsu_busy, rsu_data_out: status/data from the IP
// -----------------------------------------------------------------------------
module rsu_ctrl
   import rsu_pkg::*;
#(
   parameter int BUSY_TIMEOUT = 1023,
   parameter int RECFG_HOLD   = 4,
   parameter int WDOG_PERIOD  = 50_000_000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [2:0]  cmd_param,
   input  logic        cmd_nupdt,
   output logic        rsp_valid,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   output logic        rsu_read_param,
   output logic        rsu_reconfig,
   output logic        rsu_reset_timer,
   output logic [2:0]  rsu_param,
   output logic        rsu_ctl_nupdt,
   input  logic        rsu_busy,
   input  logic [31:0] rsu_data_out
);

   rsu_state_e       state;
   logic [TMO_W-1:0] tmo_cnt;
   logic             kick_rsp;   // command kick issued, response due next cycle
   logic             hs;
   logic             kick_now;   // a reset_timer pulse is issued at this edge
   logic             tmo_hit;
   logic             hold_done;

   assign hs        = (state == ST_IDLE) && cmd_ready && cmd_valid;
   assign tmo_hit   = (tmo_cnt >= TMO_W'(BUSY_TIMEOUT));
   assign hold_done = (tmo_cnt >= TMO_W'(RECFG_HOLD - 1));

`ifdef RSU_WDOG_EN
   logic wdog_due;

   rsu_wdog_timer #(
      .WDOG_PERIOD (WDOG_PERIOD)
   ) u_wdog (
      .clock   (clock),
      .reset_n (reset_n),
      .run     (state != ST_HALT),
      .ack     (kick_now),
      .due     (wdog_due)
   );

   // Owed kicks go out only when the IP is quiet: from IDLE when no command is
   // taken, or on the way out of RSP so the pulse lands in the first IDLE cycle.
   assign kick_now = (hs && (cmd_op == OP_WDOG_KICK)) ||
                     (wdog_due && (((state == ST_IDLE) && !hs && !kick_rsp) ||
                                   (state == ST_RSP)));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         rsu_reset_timer <= 1'b0;
      else
         rsu_reset_timer <= kick_now;
   end
`else
   logic unused_wdog_cfg;

   // The period only matters when the watchdog is built.
   assign unused_wdog_cfg = |WDOG_PERIOD;
   assign kick_now        = 1'b0;
   assign rsu_reset_timer = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state          <= ST_IDLE;
         tmo_cnt        <= '0;
         kick_rsp       <= 1'b0;
         cmd_ready      <= 1'b0;
         rsp_valid      <= 1'b0;
         rsp_data       <= '0;
         rsp_err        <= 1'b0;
         rsu_read_param <= 1'b0;
         rsu_reconfig   <= 1'b0;
         rsu_param      <= '0;
         rsu_ctl_nupdt  <= 1'b0;
      end else begin
         // Pulse outputs default low; tmo_cnt clears on every state entry.
         rsp_valid      <= 1'b0;
         rsu_read_param <= 1'b0;
         cmd_ready      <= 1'b0;
         tmo_cnt        <= '0;

         case (state)
            ST_IDLE: begin
               if (hs) begin
                  case (cmd_op)
                     OP_READ: begin
                        rsu_param      <= cmd_param;
                        rsu_ctl_nupdt  <= cmd_nupdt;
                        rsu_read_param <= 1'b1;
                        state          <= ST_RD_PULSE;
                     end
                     OP_RECONFIG: begin
                        state <= ST_RECFG;
                     end
`ifdef RSU_WDOG_EN
                     OP_WDOG_KICK: begin
                        kick_rsp <= 1'b1;
                     end
`endif
                     default: begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                        state     <= ST_RSP;
                     end
                  endcase
               end else if (kick_rsp) begin
                  kick_rsp  <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_data  <= '0;
                  state     <= ST_RSP;
               end else if (!kick_now) begin
                  cmd_ready <= 1'b1;
               end
            end

            ST_RD_PULSE: begin
               state <= ST_RD_WAIT_HI;
            end

            ST_RD_WAIT_HI: begin
               if (rsu_busy) begin
                  state <= ST_RD_WAIT_LO;
               end else if (tmo_hit) begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_data  <= timeout_word(rsu_param);
                  state     <= ST_RSP;
               end else begin
                  tmo_cnt <= sat_inc(tmo_cnt);
               end
            end

            ST_RD_WAIT_LO: begin
               if (!rsu_busy) begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_data  <= rsu_data_out;
                  state     <= ST_RSP;
               end else if (tmo_hit) begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_data  <= timeout_word(rsu_param);
                  state     <= ST_RSP;
               end else begin
                  tmo_cnt <= sat_inc(tmo_cnt);
               end
            end

            ST_RSP: begin
               state <= ST_IDLE;
               if (!kick_now)
                  cmd_ready <= 1'b1;
            end

            // rsu_reconfig low: waiting for the IP to go idle.
            // rsu_reconfig high: counting out the hold time.
            ST_RECFG: begin
               if (!rsu_reconfig) begin
                  if (!rsu_busy) begin
                     rsu_reconfig <= 1'b1;
                  end else if (tmo_hit) begin
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_data  <= timeout_word(rsu_param);
                     state     <= ST_RSP;
                  end else begin
                     tmo_cnt <= sat_inc(tmo_cnt);
                  end
               end else if (hold_done) begin
                  rsu_reconfig <= 1'b0;
                  state        <= ST_HALT;
               end else begin
                  tmo_cnt <= sat_inc(tmo_cnt);
               end
            end

            // The device reconfigures from here; only reset_n leaves.
            ST_HALT: begin
               state <= ST_HALT;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rsu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rsu_ctrl
// Directed bench for rsu_ctrl: table of READ transactions with hand-computed
// latencies and responses, plus sequences for reserved op, WDOG_KICK,
// reset during a read, and RECONFIG into HALT. RSU_WDOG_EN selects the
// watchdog-specific expectations.
// -----------------------------------------------------------------------------
module tb_rsu_ctrl;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = 2'd0;
   logic [2:0]  cmd_param = 3'd0;
   logic        cmd_nupdt = 1'b0;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic        rsu_read_param;
   logic        rsu_reconfig;
   logic        rsu_reset_timer;
   logic [2:0]  rsu_param;
   logic        rsu_ctl_nupdt;
   logic        rsu_busy = 1'b0;
   logic [31:0] rsu_data_out = 32'd0;

   int checks = 0;
   int errors = 0;

`ifdef RSU_WDOG_EN
   localparam int   KICK_LAT = 2;
   localparam logic KICK_ERR = 1'b0;
   localparam logic KICK_RT  = 1'b1;
`else
   localparam int   KICK_LAT = 1;
   localparam logic KICK_ERR = 1'b1;
   localparam logic KICK_RT  = 1'b0;
`endif

   typedef struct {
      logic [2:0]  param;
      logic        nupdt;
      int          hi_start;   // cycle after handshake where busy rises
      int          hi_len;     // busy high length (0 = never)
      logic [31:0] data;       // data_out in the first busy-low cycle
      logic [31:0] exp_data;
      logic        exp_err;
      int          exp_lat;    // cycles from handshake to rsp_valid
   } rd_vec_t;

   rd_vec_t vecs [7];

   rsu_ctrl #(
      .BUSY_TIMEOUT (15),
      .RECFG_HOLD   (4),
      .WDOG_PERIOD  (100)
   ) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_op          (cmd_op),
      .cmd_param       (cmd_param),
      .cmd_nupdt       (cmd_nupdt),
      .rsp_valid       (rsp_valid),
      .rsp_data        (rsp_data),
      .rsp_err         (rsp_err),
      .rsu_read_param  (rsu_read_param),
      .rsu_reconfig    (rsu_reconfig),
      .rsu_reset_timer (rsu_reset_timer),
      .rsu_param       (rsu_param),
      .rsu_ctl_nupdt   (rsu_ctl_nupdt),
      .rsu_busy        (rsu_busy),
      .rsu_data_out    (rsu_data_out)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_ready();
      int g = 0;
      while (cmd_ready !== 1'b1 && g < 50) begin
         step();
         g++;
      end
      chk("cmd_ready_wait", cmd_ready, 1);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_cmd_ready"}, cmd_ready, 0);
      chk({tag, "_rsp_valid"}, rsp_valid, 0);
      chk({tag, "_rsp_data"}, rsp_data, 0);
      chk({tag, "_rsp_err"}, rsp_err, 0);
      chk({tag, "_read_param"}, rsu_read_param, 0);
      chk({tag, "_reconfig"}, rsu_reconfig, 0);
      chk({tag, "_reset_timer"}, rsu_reset_timer, 0);
      chk({tag, "_param"}, rsu_param, 0);
      chk({tag, "_nupdt"}, rsu_ctl_nupdt, 0);
   endtask

   // Issues a READ in the current cycle (after ready) and plays the IP side.
   task automatic do_read(input rd_vec_t v, output logic rt_after, output logic rdy_after);
      wait_ready();
      cmd_valid = 1'b1;
      cmd_op    = 2'd0;
      cmd_param = v.param;
      cmd_nupdt = v.nupdt;
      rt_after  = 1'b0;
      rdy_after = 1'b0;
      for (int c = 1; c <= v.exp_lat + 2; c++) begin
         step();
         cmd_valid    = 1'b0;
         rsu_busy     = (c >= v.hi_start) && (c < v.hi_start + v.hi_len);
         rsu_data_out = (v.hi_len > 0 && c == v.hi_start + v.hi_len) ? v.data : 32'hBAD0_BAD0;
         chk("rd_read_param", rsu_read_param, (c == 1));
         chk("rd_rsp_valid", rsp_valid, (c == v.exp_lat));
         if (c <= v.exp_lat)
            chk("rd_reset_timer_quiet", rsu_reset_timer, 0);
         if (c == v.exp_lat) begin
            chk("rd_rsp_data", rsp_data, v.exp_data);
            chk("rd_rsp_err", rsp_err, v.exp_err);
            chk("rd_param_held", rsu_param, v.param);
            chk("rd_nupdt_held", rsu_ctl_nupdt, v.nupdt);
         end
         if (c == v.exp_lat + 1) begin
            rt_after  = rsu_reset_timer;
            rdy_after = cmd_ready;
         end
      end
      rsu_busy     = 1'b0;
      rsu_data_out = 32'd0;
   endtask

   // Single-cycle command with no IP activity (reserved op, WDOG_KICK).
   task automatic do_simple(input string tag, input logic [1:0] op, input int lat,
                            input logic exp_err, input logic exp_rt);
      wait_ready();
      cmd_valid = 1'b1;
      cmd_op    = op;
      for (int c = 1; c <= 4; c++) begin
         step();
         cmd_valid = 1'b0;
         chk({tag, "_rsp_valid"}, rsp_valid, (c == lat));
         chk({tag, "_reset_timer"}, rsu_reset_timer, (exp_rt && c == 1));
         if (c == lat) begin
            chk({tag, "_rsp_err"}, rsp_err, exp_err);
            chk({tag, "_rsp_data"}, rsp_data, 0);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not complete, got running expected finished");
      $fatal(1, "bench time limit reached");
   end

   initial begin
      logic rt, rdy;
      int   seen;

      vecs[0] = '{3'd2, 1'b0,  2,  3, 32'h1234_5678, 32'h1234_5678, 1'b0,  6};
      vecs[1] = '{3'd2, 1'b0,  0,  0, 32'h0000_0000, 32'hDEAD_0002, 1'b1, 18};
      vecs[2] = '{3'd5, 1'b1,  3,  1, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0,  5};
      vecs[3] = '{3'd7, 1'b1,  2, 40, 32'h5555_AAAA, 32'hDEAD_0007, 1'b1, 19};
      vecs[4] = '{3'd0, 1'b1,  1,  2, 32'h8000_0001, 32'h8000_0001, 1'b0,  4};
      vecs[5] = '{3'd1, 1'b0, 17,  1, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 1'b0, 19};
      vecs[6] = '{3'd3, 1'b1, 18,  2, 32'h7777_7777, 32'hDEAD_0003, 1'b1, 18};

      // Reset state
      step();
      step();
      check_all_zero("reset");
      reset_n = 1'b1;
      step();

`ifdef RSU_WDOG_EN
      // Sync to the first automatic pulse, then start a READ two cycles
      // before the next tick so that tick must be deferred past RSP.
      begin
         int g = 0;
         while (rsu_reset_timer !== 1'b1 && g < 300) begin
            step();
            g++;
         end
         chk("wdog_first_pulse", rsu_reset_timer, 1);
         chk("wdog_pulse_ready_low", cmd_ready, 0);
         repeat (97) step();
         do_read(vecs[0], rt, rdy);
         chk("wdog_deferred_pulse", rt, 1);
         chk("wdog_deferred_ready_low", rdy, 0);
      end
`endif

      // Table-driven READ transactions
      for (int i = 0; i < 7; i++) begin
         do_read(vecs[i], rt, rdy);
`ifndef RSU_WDOG_EN
         chk("rd_idle_reset_timer", rt, 0);
         chk("rd_idle_ready", rdy, 1);
`endif
      end

      // Reserved opcode
      do_simple("rsvd", 2'd3, 1, 1'b1, 1'b0);

      // WDOG_KICK command
      do_simple("kick", 2'd2, KICK_LAT, KICK_ERR, KICK_RT);

      // Reset asserted while in RD_WAIT_LO
      wait_ready();
      cmd_valid = 1'b1;
      cmd_op    = 2'd0;
      cmd_param = 3'd6;
      cmd_nupdt = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         step();
         cmd_valid = 1'b0;
         rsu_busy  = (c >= 2);
      end
      chk("pre_reset_param", rsu_param, 6);
      chk("pre_reset_nupdt", rsu_ctl_nupdt, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check_all_zero("midreset");
      step();
      step();
      reset_n  = 1'b1;
      rsu_busy = 1'b0;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         step();
         if (rsp_valid === 1'b1) seen++;
      end
      chk("no_rsp_after_reset", seen, 0);
      do_read(vecs[0], rt, rdy);

      // RECONFIG while busy is high for 5 cycles, then HALT
      wait_ready();
      cmd_valid = 1'b1;
      cmd_op    = 2'd1;
      for (int c = 1; c <= 14; c++) begin
         step();
         cmd_valid = 1'b0;
         rsu_busy  = (c <= 5);
         chk("recfg_reconfig", rsu_reconfig, (c >= 7 && c <= 10));
         chk("recfg_ready_low", cmd_ready, 0);
         chk("recfg_no_rsp", rsp_valid, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rsu_ctrl.md
# rsu_ctrl

Sequencer that drives the remote-system-update IP port set (`read_param`, `param`, `reconfig`, `reset_timer`, `ctl_nupdt`, `busy`, `data_out`). It accepts single-beat commands from the board-management/packet-decode logic, runs the IP's read handshake, and returns one 32-bit response per read. It also issues the reconfiguration trigger and services the configuration watchdog. It sits directly upstream of `rsu` and is the only block that drives it.

## Interface
- `BUSY_TIMEOUT`, default 1023: maximum number of cycles to wait for each `busy` edge.
- `RECFG_HOLD`, default 4: number of cycles `rsu_reconfig` is held high.
- `WDOG_PERIOD`, default 50_000_000: cycles between automatic watchdog kicks (used only when the watchdog is compiled in).
- `clock` in 1: the single clock for the block.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command strobe.
- `cmd_ready` out 1: block can accept a command.
- `cmd_op` in 2: 0 READ, 1 RECONFIG, 2 WDOG_KICK, 3 reserved.
- `cmd_param` in 3: parameter index for READ.
- `cmd_nupdt` in 1: value driven onto `ctl_nupdt` for READ.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_data` out 32: captured `data_out`.
- `rsp_err` out 1: timeout or unsupported operation.
- `rsu_read_param`, `rsu_reconfig`, `rsu_reset_timer` out 1: drive the IP.
- `rsu_param` out 3: drives the IP.
- `rsu_ctl_nupdt` out 1: drives the IP.
- `rsu_busy` in 1: from the IP.
- `rsu_data_out` in 32: from the IP.

## Operation
- FSM states: IDLE, RD_PULSE, RD_WAIT_HI, RD_WAIT_LO, RSP, RECFG, HALT.
- IDLE:
  - `cmd_ready` = 1 when no watchdog kick is pending; a handshake occurs when `cmd_valid & cmd_ready`.
  - READ: latch `cmd_param` and `cmd_nupdt` into `rsu_param` and `rsu_ctl_nupdt`, then go to RD_PULSE.
  - RECONFIG: go to RECFG.
  - WDOG_KICK: pulse `rsu_reset_timer` for 1 cycle, then go to RSP with `rsp_err` = 0.
  - Reserved op: go to RSP with `rsp_err` = 1 and `rsp_data` = 0.
- RD_PULSE: `rsu_read_param` = 1 for exactly 1 cycle, then go to RD_WAIT_HI.
- RD_WAIT_HI: wait for `rsu_busy` = 1, then go to RD_WAIT_LO and reset the timeout counter.
- RD_WAIT_LO: wait for `rsu_busy` = 0; capture `rsu_data_out` in the cycle `busy` is sampled low, then go to RSP.
- Either wait state: when the counter reaches `BUSY_TIMEOUT`, go to RSP with `rsp_err` = 1 and `rsp_data` = 0xDEAD_0000 | param.
- RSP: `rsp_valid` = 1 for 1 cycle, then return to IDLE. The response channel has no backpressure.
- RECFG:
  - Wait for `rsu_busy` = 0, then hold `rsu_reconfig` = 1 for `RECFG_HOLD` cycles, then go to HALT.
  - This wait is also subject to `BUSY_TIMEOUT`; on timeout go to RSP with `rsp_err` = 1 and do not assert `rsu_reconfig`.
- HALT: `cmd_ready` = 0 forever. Only `reset_n` exits HALT (the device reconfigures).
- `rsu_param` and `rsu_ctl_nupdt` are held stable from latch until the next READ is accepted.
- Timeout counter: 16 bits, saturating, cleared on each state entry.

## Timing
- Reset values: every output is 0, including `rsu_param` = 0 and `rsu_ctl_nupdt` = 0. State resets to IDLE and the pending-kick flag is cleared.
- READ latency:
  - Cycle N: handshake.
  - Cycle N+1: `read_param` high.
  - `rsp_valid` goes high 1 cycle after the cycle `busy` is first sampled low in RD_WAIT_LO.
  - With a 3-cycle `busy` pulse starting at N+2, `rsp_valid` is high at N+6.
- WDOG_KICK latency: `reset_timer` high at N+1, `rsp_valid` high at N+2.
- All IP-facing outputs are registered. No combinational path exists from `rsu_*` inputs to outputs.
- When `reset_n` is asserted mid-operation, all outputs drop immediately (asynchronous reset) and any in-flight response is lost.

## Configuration
- The macro `RSU_WDOG_EN` selects the watchdog behaviour.
- Defined:
  - A free-running counter pulses `rsu_reset_timer` for 1 cycle every `WDOG_PERIOD` cycles.
  - If the tick occurs outside IDLE, a pending flag is set and the pulse is issued on the first IDLE cycle, with `cmd_ready` = 0 in that cycle.
  - A tick that coincides with a command WDOG_KICK produces a single pulse.
  - Ticks stop in HALT.
- Undefined:
  - No counter is built and `rsu_reset_timer` is tied to 0.
  - The WDOG_KICK op responds with `rsp_err` = 1.

## Structure
- Package `rsu_pkg`: the `cmd_op` enum (READ, RECONFIG, WDOG_KICK), the FSM state enum, the parameter-index constants for `param`, and the timeout error pattern 0xDEAD_0000.
- Sub-module `rsu_wdog_timer`: period counter plus pending-flag logic, instantiated only under `RSU_WDOG_EN`.

## Test plan
- READ param 3'b010 with `nupdt` = 0, and the IP model drives `busy` high for 3 cycles with `data_out` = 0x1234_5678 → `read_param` pulses once, `rsp_data` = 0x1234_5678, `rsp_err` = 0, latency as in Timing.
- READ with `busy` never asserted and `BUSY_TIMEOUT` = 15 → `rsp_err` = 1 and `rsp_data` = 0xDEAD_0002 after 16 wait cycles.
- RECONFIG while `busy` = 1 for 5 cycles → `rsu_reconfig` stays 0 until `busy` falls, is then high for exactly 4 cycles, and `cmd_ready` stays 0 afterwards.
- With `RSU_WDOG_EN` and `WDOG_PERIOD` = 100, start a READ when the tick is due 2 cycles later → the tick is deferred, `reset_timer` pulses in the first IDLE cycle after RSP, and `cmd_ready` is 0 in that cycle.
- Without `RSU_WDOG_EN`, issue a WDOG_KICK → `rsu_reset_timer` never toggles, and `rsp_valid` comes with `rsp_err` = 1.
- Assert `reset_n` during RD_WAIT_LO → all outputs are 0 immediately and no response is emitted; a new READ after reset completes normally.
